// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the floating-point units (fdiv, fmul).
// Holds the field widths, the special encodings and the divider state type.
package fp_pkg;

    localparam int SIGN_W  = 1;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int N_ITER  = 25;     // quotient bits, one per DIVIDE cycle

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_NAN  = 2'd1,
        SP_INF  = 2'd2,
        SP_ZERO = 2'd3
    } special_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 field splitter and class decoder, shared by fdiv and fmul.
// Subnormals (exponent field 0) are reported as zero.
module fp32_classify
    import fp_pkg::*;
(
    input  logic [31:0]       i_word,
    output logic              o_is_zero,
    output logic              o_is_inf,
    output logic              o_is_nan,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_exp,
    output logic [FRAC_W:0]   o_mant
);

    logic [FRAC_W-1:0] w_frac;
    logic              w_exp_zero;
    logic              w_exp_ones;

    assign o_sign     = i_word[31];
    assign o_exp      = i_word[30:23];
    assign w_frac     = i_word[22:0];
    assign w_exp_zero = (o_exp == '0);
    assign w_exp_ones = (o_exp == '1);

    assign o_is_zero  = w_exp_zero;
    assign o_is_inf   = w_exp_ones && (w_frac == '0);
    assign o_is_nan   = w_exp_ones && (w_frac != '0);
    assign o_mant     = {~w_exp_zero, w_frac};

endmodule

// File: rtl/fdiv.sv
// Iterative FP32 divider: restoring mantissa divide, one quotient bit per cycle,
// round-toward-zero, fixed 27-cycle start-to-done latency for every operand class.
module fdiv
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    logic              w_a_zero, w_a_inf, w_a_nan, w_a_sign;
    logic              w_b_zero, w_b_inf, w_b_nan, w_b_sign;
    logic [EXP_W-1:0]  w_a_exp, w_b_exp;
    logic [FRAC_W:0]   w_a_mant, w_b_mant;

    fp32_classify u_class_a (
        .i_word    (a_in),
        .o_is_zero (w_a_zero),
        .o_is_inf  (w_a_inf),
        .o_is_nan  (w_a_nan),
        .o_sign    (w_a_sign),
        .o_exp     (w_a_exp),
        .o_mant    (w_a_mant)
    );

    fp32_classify u_class_b (
        .i_word    (b_in),
        .o_is_zero (w_b_zero),
        .o_is_inf  (w_b_inf),
        .o_is_nan  (w_b_nan),
        .o_sign    (w_b_sign),
        .o_exp     (w_b_exp),
        .o_mant    (w_b_mant)
    );

    special_t          w_special;
    logic signed [9:0] w_exp_init;

    // NaN takes priority, then the inf outcomes, then the zero outcomes.
    always_comb begin
        w_special = SP_NONE;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf))
            w_special = SP_NAN;
        else if (w_a_inf || w_b_zero)
            w_special = SP_INF;
        else if (w_a_zero || w_b_inf)
            w_special = SP_ZERO;
    end

    assign w_exp_init = $signed({2'b00, w_a_exp}) - $signed({2'b00, w_b_exp})
                      + $signed(10'(BIAS));

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [31:0]        r_result;
    logic               r_sign;
    special_t           r_special;
    logic signed [9:0]  r_exp;
    logic [FRAC_W+1:0]  r_rem;
    logic [FRAC_W:0]    r_div;
    logic [N_ITER-1:0]  r_q;
    logic [FRAC_W-1:0]  r_frac;
    logic [4:0]         r_cnt;

    logic               w_ge;
    logic [FRAC_W+1:0]  w_rem_next;
    logic [31:0]        w_packed;

    // After a subtract the remainder is below the divisor, so the shift never loses a bit.
    assign w_ge       = (r_rem >= {1'b0, r_div});
    assign w_rem_next = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

    always_comb begin
        w_packed = {r_sign, 31'h0};
        case (r_special)
            SP_NAN:  w_packed = QNAN;
            SP_INF:  w_packed = {r_sign, POS_INF[30:0]};
            SP_ZERO: w_packed = {r_sign, 31'h0};
            default: begin
                if (r_exp >= $signed(10'(EXP_MAX)))
                    w_packed = {r_sign, POS_INF[30:0]};
                else if (r_exp <= 10'sd0)
                    w_packed = {r_sign, 31'h0};
                else
                    w_packed = {r_sign, r_exp[EXP_W-1:0], r_frac};
            end
        endcase
    end

    // NOTE: only control state and outputs are reset; the datapath registers are
    // always loaded on the accepting edge before anything reads them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state   <= DIVIDE;
                        r_busy    <= 1'b1;
                        r_sign    <= w_a_sign ^ w_b_sign;
                        r_special <= w_special;
                        r_exp     <= w_exp_init;
                        r_rem     <= {1'b0, w_a_mant};
                        r_div     <= w_b_mant;
                        r_q       <= '0;
                        r_cnt     <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                DIVIDE: begin
                    if (r_cnt != 5'(N_ITER)) begin
                        r_rem <= {w_rem_next[FRAC_W:0], 1'b0};
                        r_q   <= {r_q[N_ITER-2:0], w_ge};
                        r_cnt <= r_cnt + 5'd1;
                    end else begin
                        if (r_q[N_ITER-1]) begin
                            r_frac <= r_q[FRAC_W:1];
                        end else begin
                            r_frac <= r_q[FRAC_W-1:0];
                            r_exp  <= r_exp - 10'sd1;
                        end
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    r_result <= w_packed;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_fdiv.sv
// Self-checking bench for fdiv: directed spec vectors plus randomized operands,
// scored against an arithmetic reference model with a timing-aware scoreboard.
module tb_fdiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    fdiv dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          free_at = 0;   // first cycle index at which the divider reports not busy
    logic [31:0] held = '0;     // value result must hold between done pulses
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at cycle %0d", name, act, want, cyc);
        end
    endtask

    // Reference quotient from the IEEE field rules using plain integer arithmetic.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        int                ea, eb, e;
        logic [22:0]       fa, fb, frac;
        bit                az, ai, an, bz, bi, bn;
        longint unsigned   ma, mb, q;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        az = (ea == 0);
        ai = (ea == 255) && (fa == 0);
        an = (ea == 255) && (fa != 0);
        bz = (eb == 0);
        bi = (eb == 255) && (fb == 0);
        bn = (eb == 255) && (fb != 0);
        if (an || bn || (az && bz) || (ai && bi)) return 32'h7FC00000;
        if (ai || bz) return {s, 31'h7F800000};
        if (az || bi) return {s, 31'h0};
        ma = 64'h800000 + longint'(fa);
        mb = 64'h800000 + longint'(fb);
        q  = (ma << 24) / mb;
        if (q >= 64'h1000000) begin
            frac = 23'(q >> 1);
            e    = ea - eb + 127;
        end else begin
            frac = 23'(q);
            e    = ea - eb + 126;
        end
        if (e >= 255) return {s, 31'h7F800000};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), frac};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 15);
        case (k)
            0:       return {r[31], 31'h0};
            1:       return {r[31], 8'hFF, 23'h0};
            2:       return {r[31], 8'hFF, r[22:1], 1'b1};
            3:       return {r[31], 8'h00, r[22:0]};
            4:       return {r[31], 8'(254 - $urandom_range(0, 3)), r[22:0]};
            5:       return {r[31], 8'($urandom_range(1, 4)), r[22:0]};
            default: return {r[31], 8'($urandom_range(100, 154)), r[22:0]};
        endcase
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("busy", 32'(busy), 32'(cyc < free_at));
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check("done_pulse", 32'(done), 32'd1);
                check("result", result, sb[0].res);
                held = sb[0].res;
                void'(sb.pop_front());
            end else begin
                check("done_idle", 32'(done), 32'd0);
                check("result_hold", result, held);
            end
        end
    end

    // Called at a falling edge; drives start for one cycle and scrambles the operands after.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
        exp_t e;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        if (cyc >= free_at) begin
            e.res = want;
            e.due = cyc + 28;
            sb.push_back(e);
            free_at = cyc + 28;
        end
        @(negedge clk);
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
    endtask

    task automatic issue_rand();
        logic [31:0] a, b;
        a = rand_fp();
        b = rand_fp();
        issue(a, b, ref_div(a, b));
    endtask

    task automatic wait_done_cycle();
        int lim = 0;
        while (cyc != free_at && lim < 100) begin
            @(negedge clk);
            lim++;
        end
    endtask

    task automatic drain();
        int lim = 0;
        while (sb.size() > 0 && lim < 200) begin
            @(negedge clk);
            lim++;
        end
        n_checks++;
        if (sb.size() > 0) begin
            n_errors++;
            $display("FAIL drain: %0d results still outstanding at cycle %0d", sb.size(), cyc);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst     = 1'b1;
        sb.delete();
        free_at = 0;
        held    = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(32'h42280000, 32'h40C00000, 32'h40E00000);
        drain();

        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
        wait_done_cycle();
        issue(32'hC0C00000, 32'h40000000, 32'hC0400000);
        drain();

        issue(32'h3F800000, 32'h00000000, 32'h7F800000);
        drain();
        issue(32'h00000000, 32'h00000000, 32'h7FC00000);
        drain();
        issue(32'h7F800000, 32'h7F800000, 32'h7FC00000);
        drain();
        issue(32'h7F000000, 32'h00800000, 32'h7F800000);
        drain();
        issue(32'h00800000, 32'h7F000000, 32'h00000000);
        drain();

        // A second start five edges into a divide must be ignored.
        issue(32'h42280000, 32'h40C00000, 32'h40E00000);
        repeat (4) @(negedge clk);
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
        drain();

        // Reset landing on the tenth edge of a divide aborts it without a done pulse.
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
        repeat (9) @(negedge clk);
        pulse_reset();
        repeat (30) @(negedge clk);
        issue(32'hC0C00000, 32'h40000000, 32'hC0400000);
        drain();

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0)
                wait_done_cycle();
            else
                repeat ($urandom_range(0, 35)) @(negedge clk);
            issue_rand();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fdiv.md
FDIV -- requirements
Module: fdiv

Interface
REQ-001 The module SHALL have a single clock and a synchronous, active-high reset: clock port clk, reset port rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset, sampled on the clk rising edge.
REQ-004 start  input  1  request to begin a divide, sampled each rising edge.
REQ-005 a_in  input  32  IEEE-754 single dividend.
REQ-006 b_in  input  32  IEEE-754 single divisor.
REQ-007 busy  output  1  high while a divide is in progress.
REQ-008 done  output  1  one-cycle pulse marking result valid.
REQ-009 result  output  32  IEEE-754 single quotient a_in/b_in; holds its value until the next done.

Function
REQ-010 start SHALL be accepted only on a rising edge where busy is 0; start while busy=1 SHALL be ignored.
REQ-011 a_in and b_in SHALL be captured on the accepting edge; later operand changes SHALL NOT affect the operation.
REQ-012 States SHALL be: IDLE, DIVIDE, NORM, DONE.
REQ-013 State transitions SHALL be: IDLE->DIVIDE on accepted start; DIVIDE->NORM after exactly 25 iterations; NORM->DONE; DONE->IDLE, or DONE->DIVIDE on accepted start (back-to-back).
REQ-014 busy SHALL be 1 in DIVIDE and NORM, and 0 in IDLE and DONE.
REQ-015 done SHALL be 1 only in DONE, exactly 27 rising edges after the accepting edge, for all operand classes (fixed latency).
REQ-016 The mantissa datapath SHALL use {1,frac} for both operands, a restoring divide producing one quotient bit per DIVIDE cycle, and 25 quotient bits.
REQ-017 If quotient bit 24 is 1, the mantissa SHALL be bits [23:1] and the exponent ea-eb+127; otherwise the mantissa SHALL be bits [22:0] and the exponent ea-eb+126.
REQ-018 Rounding SHALL be round-toward-zero (truncate), consistent with fmul.
REQ-019 The sign SHALL be sign(a) XOR sign(b) for every non-NaN result.
REQ-020 Inputs with exponent field 0 SHALL be treated as signed zero (subnormals flushed).
REQ-021 A biased result exponent >=255 SHALL produce signed infinity; a biased result exponent <=0 SHALL produce signed zero.
REQ-022 Any NaN input, 0/0, or inf/inf SHALL produce canonical NaN 0x7FC00000.
REQ-023 For other zero-or-infinite divisor and dividend combinations: finite-nonzero/0 and inf/finite SHALL produce signed inf; 0/finite-nonzero and finite/inf SHALL produce signed zero.
REQ-024 Special-case results SHALL be decided at capture and SHALL still use the REQ-015 latency.

Reset
REQ-025 While rst=1, the state SHALL go to IDLE, busy=0, done=0, and result=0x00000000, overriding start.
REQ-026 rst asserted mid-operation SHALL abort the divide with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-027 The shared package fp_pkg SHALL hold the FP32 field widths (1/8/23), BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, POS_INF=32'h7F800000, and the state encoding.
REQ-028 The block SHALL contain one sub-module, fp32_classify, which is combinational and shared with fmul. It takes a 32-bit word and produces is_zero, is_inf, is_nan, sign, exp, and mant.
REQ-029 The target implementation size SHALL be 120-400 lines of RTL.

Verification
REQ-030 a=0x42280000 (42.0), b=0x40C00000 (6.0), start pulse -> done 27 cycles later, result=0x40E00000 (7.0).
REQ-031 a=0x3F800000 (1.0), b=0x40400000 (3.0) -> result=0x3EAAAAAA (truncated); then a=0xC0C00000 (-6.0), b=0x40000000 (2.0) started in the DONE cycle -> result=0xC0400000 (-3.0) after 27 more cycles.
REQ-032 1.0/0.0 -> 0x7F800000; 0.0/0.0 -> 0x7FC00000; 0x7F800000/0x7F800000 -> 0x7FC00000; each with done at cycle 27.
REQ-033 a=0x7F000000, b=0x00800000 -> result=0x7F800000 (overflow); a=0x00800000, b=0x7F000000 -> result=0x00000000 (underflow).
REQ-034 Start accepted, second start at cycle 5 with different operands -> ignored, first result delivered; rst pulsed at cycle 10 of a divide -> no done, outputs 0, next start completes correctly.
